// File: rtl/gemm_stream_ctrl.sv
// ---------------------------------------------------------------------------
// gemm_stream_ctrl
//
// Sequences one GEMM job on an external SA_SIZE x SA_SIZE systolic array:
// loads the weight matrix, streams num_rows activation rows into the array,
// pushes 2*SA_SIZE-1 zero rows to drain the pipeline, and forwards the result
// rows to a downstream consumer.
//
// Ports
//   clk, resetn          : rising-edge clock, synchronous active-low reset
//   start, num_rows,
//   weights_in           : job request (sampled in IDLE only)
//   in_valid/in_ready/
//   in_data              : input activation row stream
//   out_valid/out_ready/
//   out_data/out_last    : result row stream (out_last marks the final row)
//   weight_inputs,
//   activation_inputs,
//   cmd                  : command side towards the systolic array
//   activation_outputs,
//   output_valid         : result side from the systolic array
//   busy, done           : job status (done is a 1-cycle pulse)
//   protocol_err         : sticky, set when a result is offered while the
//                          array reports no valid output
//   dbg_state            : current FSM state
//
// Handshake rule (both streams): a transfer happens in a cycle where valid
// and ready are both 1. A producer holds valid and data stable until that
// cycle; ready never depends on valid of the same interface.
// ---------------------------------------------------------------------------
package GEMM_pkg;
    typedef enum logic [1:0] {
        CMD_NONE          = 2'd0,
        CMD_WRITE_WEIGHTS = 2'd1,
        CMD_STREAM        = 2'd2
    } command_t;
endpackage

module gemm_stream_ctrl
    import GEMM_pkg::*;
#(
    parameter int SA_SIZE         = 4,
    parameter int ACTIVATION_SIZE = 8,
    parameter int MAX_ROWS        = 16
) (
    input  logic                                              clk,
    input  logic                                              resetn,
    input  logic                                              start,
    input  logic [$clog2(MAX_ROWS+1)-1:0]                     num_rows,
    input  logic [SA_SIZE-1:0][SA_SIZE-1:0][ACTIVATION_SIZE-1:0] weights_in,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]           in_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]           out_data,
    output logic                                              out_last,
    output logic [SA_SIZE-1:0][SA_SIZE-1:0][ACTIVATION_SIZE-1:0] weight_inputs,
    output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]           activation_inputs,
    output command_t                                          cmd,
    input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]           activation_outputs,
    input  logic                                              output_valid,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              protocol_err,
    output logic [2:0]                                        dbg_state
);

    localparam int ROWS_W      = $clog2(MAX_ROWS + 1);
    localparam int FLUSH_BEATS = 2 * SA_SIZE - 1;
    localparam int FL_W        = $clog2(FLUSH_BEATS + 1);
    localparam int BEAT_W      = $clog2(MAX_ROWS + FLUSH_BEATS + 1);

    localparam logic [ROWS_W-1:0] MAX_ROWS_V   = ROWS_W'(MAX_ROWS);
    localparam logic [FL_W-1:0]   FLUSH_DONE_V = FL_W'(FLUSH_BEATS);
    localparam logic [FL_W-1:0]   FLUSH_LAST_V = FL_W'(FLUSH_BEATS - 1);
    // The first beat whose result leaves the array is beat 2*SA_SIZE-1.
    localparam logic [BEAT_W-1:0] PRODUCE_V    = BEAT_W'(FLUSH_BEATS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e                                              state_q, state_d;
    logic [ROWS_W-1:0]                                   rows_q, rows_d;
    logic [ROWS_W-1:0]                                   in_cnt_q, in_cnt_d;
    logic [FL_W-1:0]                                     flush_cnt_q, flush_cnt_d;
    logic [BEAT_W-1:0]                                   beat_cnt_q, beat_cnt_d;
    logic [SA_SIZE-1:0][SA_SIZE-1:0][ACTIVATION_SIZE-1:0] weights_q, weights_d;
    logic                                                out_valid_q, out_valid_d;
    logic                                                out_last_q, out_last_d;
    logic                                                protocol_err_q, protocol_err_d;

    logic go;         // downstream can absorb whatever the next beat produces
    logic beat;       // this cycle issues CMD_STREAM
    logic producing;  // this beat yields a result row next cycle
    logic out_hs;

    assign go     = !out_valid_q || out_ready;
    assign out_hs = out_valid_q && out_ready;

    // -----------------------------------------------------------------------
    // Next-state, command and counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d           = state_q;
        rows_d            = rows_q;
        in_cnt_d          = in_cnt_q;
        flush_cnt_d       = flush_cnt_q;
        weights_d         = weights_q;
        cmd               = CMD_NONE;
        activation_inputs = '0;
        in_ready          = 1'b0;
        beat              = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((num_rows != '0) && (num_rows <= MAX_ROWS_V)) begin
                        rows_d      = num_rows;
                        weights_d   = weights_in;
                        in_cnt_d    = '0;
                        flush_cnt_d = '0;
                        state_d     = S_LOAD_W;
                    end else begin
                        // Empty or oversize job: report completion, touch nothing.
                        state_d = S_DONE;
                    end
                end
            end

            S_LOAD_W: begin
                cmd     = CMD_WRITE_WEIGHTS;
                state_d = S_STREAM;
            end

            S_STREAM: begin
                in_ready = go;
                if (in_valid && go) begin
                    beat              = 1'b1;
                    cmd               = CMD_STREAM;
                    activation_inputs = in_data;
                    in_cnt_d          = in_cnt_q + ROWS_W'(1);
                    if ((in_cnt_q + ROWS_W'(1)) == rows_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                if (flush_cnt_q != FLUSH_DONE_V) begin
                    if (go) begin
                        beat        = 1'b1;
                        cmd         = CMD_STREAM;
                        flush_cnt_d = flush_cnt_q + FL_W'(1);
                    end
                end else if (go) begin
                    // All drain beats issued; leave once the last row is taken.
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Beat counter and result-stream registers
    // -----------------------------------------------------------------------
    always_comb begin
        beat_cnt_d     = beat_cnt_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        producing      = beat && (beat_cnt_q >= PRODUCE_V);
        protocol_err_d = protocol_err_q || (out_valid_q && !output_valid);

        if ((state_q == S_IDLE) && (state_d == S_LOAD_W)) begin
            beat_cnt_d = '0;
        end else if (beat) begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end

        if (producing) begin
            out_valid_d = 1'b1;
            // The last result row always comes from the final drain beat.
            out_last_d  = (state_q == S_FLUSH) && (flush_cnt_q == FLUSH_LAST_V);
        end else if (out_hs) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            rows_q         <= '0;
            in_cnt_q       <= '0;
            flush_cnt_q    <= '0;
            beat_cnt_q     <= '0;
            weights_q      <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rows_q         <= rows_d;
            in_cnt_q       <= in_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            beat_cnt_q     <= beat_cnt_d;
            weights_q      <= weights_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign out_data      = activation_outputs;
    assign weight_inputs = weights_q;
    assign protocol_err  = protocol_err_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign dbg_state     = state_q;

endmodule
